branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
Resolves conditional branches against the prediction made at decode. It is the consumer of `pred_takeD` and `branchD`, and the producer of `branchM`, `actual_takeM` and `pcM`, which feed the predictor's BHT/PHT update. It carries the prediction from D through E to M, detects a mispredict in E, and issues a redirect PC plus front-end flush. It also drives the predictor update port at M.

Parameters:
- `PC_W`, 32, width of all PC/target buses.
- `CNT_W`, 32, width of statistics counters (used only with `BRANCH_STAT_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `branchD`  in  1  instruction in D is a conditional branch.
- `pred_takeD`  in  1  predictor's taken prediction for the D instruction.
- `pcD`  in  `PC_W`  PC of the D instruction.
- `targetD`  in  `PC_W`  taken target computed in D.
- `stallE`  in  1  hold the D->E register.
- `flushE`  in  1  clear the D->E register (bubble).
- `stallM`  in  1  hold the E->M register.
- `flushM`  in  1  clear the E->M register.
- `actual_takeE`  in  1  branch condition evaluated by the E comparator.
- `mispredictE`  out  1  branch in E resolved opposite to its prediction.
- `redirect_pcE`  out  `PC_W`  correct next fetch PC when `mispredictE`=1.
- `flush_frontE`  out  1  one-shot flush request for F/D on mispredict.
- `branchM`  out  1  M holds a resolved branch; the predictor update enable.
- `actual_takeM`  out  1  resolved direction of the M branch.
- `pcM`  out  `PC_W`  PC of the M instruction (predictor index source).
- `mispredM`  out  1  M branch was mispredicted (for debug/stats).
- `br_countM`  out  `CNT_W`  branches retired from M (feature only).
- `mp_countM`  out  `CNT_W`  mispredicts retired from M (feature only).

Behaviour:
- **Reset.** `resetn`=0 clears both pipeline registers, the `fired` flag and the counters immediately, without waiting for a clock. While reset is asserted every output is 0.
- **D->E register** holds `{branchE, predE, pcE, targetE}`.
  - Priority: `flushE` > `stallE` > load.
  - Load captures `{branchD, branchD & pred_takeD, pcD, targetD}`.
- **E logic (combinational).**
  - `mispredictE` = `branchE & (predE ^ actual_takeE)`.
  - `redirect_pcE` = `actual_takeE ? targetE : pcE + 8` (delay slot). Add modulo 2^`PC_W`; wrap-around is allowed.
  - `redirect_pcE` = 0 when `mispredictE`=0.
- **One-shot flush.**
  - A `fired` flag sets when `mispredictE & stallE`.
  - It clears when E is reloaded or flushed.
  - `flush_frontE` = `mispredictE & ~fired`. A branch held in E by a stall therefore requests the front-end flush only in its first E cycle. `mispredictE` and `redirect_pcE` stay asserted for the whole stall.
- **E->M register** holds `{branchM, actual_takeM, pcM, mispredM}`.
  - Priority: `flushM` > `stallM` > load.
  - Load captures `{branchE, branchE & actual_takeE, pcE, mispredictE}`.
  - When E is stalled but M is not, M loads a bubble (all fields 0). This prevents a double predictor update.
- **Latency.** A branch entering D at cycle t reaches E at t+1 and M at t+2, assuming no stalls. `branchM` is high for exactly one cycle per branch when `stallM`=0.
- **Non-branches.** Non-branch instructions propagate with `branchM`=0, so the predictor performs no update for them.
- **Simultaneous events.**
  - `flushE` with `stallE`: the bubble wins.
  - A mispredict in E coinciding with `flushE` still reports this cycle. The flush affects only the next register state.

Optional Feature:
- Macro: `BRANCH_STAT_EN`.
- Defined: two `CNT_W` counters, reset to 0.
  - `br_countM` increments when `branchM & ~stallM`.
  - `mp_countM` increments when `mispredM & ~stallM`.
  - Both saturate at all-ones; they do not wrap.
- Undefined: no counter flops; `br_countM` and `mp_countM` are tied to 0.

Test Plan:
- **Correct prediction.** `branchD`=1, `pred_takeD`=1, `pcD`=0x100, `targetD`=0x200, then `actual_takeE`=1 → `mispredictE`=0. Two cycles later `branchM`=1, `actual_takeM`=1, `pcM`=0x100.
- **Predicted taken, actually not taken.** `pred_takeD`=1, `actual_takeE`=0, `pcD`=0x100 → `mispredictE`=1, `redirect_pcE`=0x108, `flush_frontE`=1 for 1 cycle. Next cycle `mispredM`=1.
- **Mispredict under stall.** Predicted not-taken, `actual_takeE`=1, `stallE`=1 for 3 cycles → `mispredictE`=1 for 4 cycles with `redirect_pcE`=0x200. `flush_frontE` is high only in the first cycle. `branchM` pulses once.
- **Flush, reset and wrap.**
  - `flushE` while `branchD`=1 → no `mispredictE`, no `branchM` pulse.
  - Drop `resetn` mid-stall → all outputs 0 asynchronously.
  - `pcD`=0xFFFF_FFFC, predicted taken but not taken → `redirect_pcE`=0x0000_0004.
- **Counters (`BRANCH_STAT_EN`).** Preload `br_countM` to all-ones via 2^`CNT_W`-1 branches (use `CNT_W`=4), plus 10 more → `br_countM` holds 0xF. Five mispredicts → `mp_countM`=5.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: carries the decode-time branch prediction from D through E
// to M. It flags a mispredict in E, supplies the redirect PC and a one-shot
// front-end flush, and drives the predictor update signals at M.
// Optional feature: define BRANCH_STAT_EN to add saturating counters for
// retired branches and mispredicts. Without it, both count outputs are 0.
module branch_resolve #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             branchD,
  input  logic             pred_takeD,
  input  logic [PC_W-1:0]  pcD,
  input  logic [PC_W-1:0]  targetD,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             stallM,
  input  logic             flushM,
  input  logic             actual_takeE,
  output logic             mispredictE,
  output logic [PC_W-1:0]  redirect_pcE,
  output logic             flush_frontE,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [PC_W-1:0]  pcM,
  output logic             mispredM,
  output logic [CNT_W-1:0] br_countM,
  output logic [CNT_W-1:0] mp_countM
);

  logic            branchE, predE, fired;
  logic [PC_W-1:0] pcE, targetE;

  // D->E register: a flush inserts a bubble, a stall holds, otherwise load.
  // The prediction is masked with branchD so that a non-branch never carries a prediction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branchE <= 1'b0;
      predE   <= 1'b0;
      pcE     <= '0;
      targetE <= '0;
    end else if (flushE) begin
      branchE <= 1'b0;
      predE   <= 1'b0;
      pcE     <= '0;
      targetE <= '0;
    end else if (!stallE) begin
      branchE <= branchD;
      predE   <= branchD & pred_takeD;
      pcE     <= pcD;
      targetE <= targetD;
    end
  end

  // Resolve in E. On a not-taken mispredict, the fallthrough address skips
  // the delay slot (pc + 8). The addition wraps modulo 2^PC_W.
  always_comb begin
    mispredictE  = branchE & (predE ^ actual_takeE);
    redirect_pcE = '0;
    if (mispredictE)
      redirect_pcE = actual_takeE ? targetE : pcE + PC_W'(8);
    flush_frontE = mispredictE & ~fired;
  end

  // fired remembers that the flush was already requested for the branch held in E.
  // It clears whenever E takes new contents (reload or bubble).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      fired <= 1'b0;
    else if (flushE || !stallE)
      fired <= 1'b0;
    else if (mispredictE)
      fired <= 1'b1;
  end

  // E->M register. While E is stalled, M takes a bubble instead of a copy.
  // This means a held branch updates the predictor only once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branchM      <= 1'b0;
      actual_takeM <= 1'b0;
      pcM          <= '0;
      mispredM     <= 1'b0;
    end else if (flushM) begin
      branchM      <= 1'b0;
      actual_takeM <= 1'b0;
      pcM          <= '0;
      mispredM     <= 1'b0;
    end else if (!stallM) begin
      if (stallE) begin
        branchM      <= 1'b0;
        actual_takeM <= 1'b0;
        pcM          <= '0;
        mispredM     <= 1'b0;
      end else begin
        branchM      <= branchE;
        actual_takeM <= branchE & actual_takeE;
        pcM          <= pcE;
        mispredM     <= mispredictE;
      end
    end
  end

`ifdef BRANCH_STAT_EN
  logic [CNT_W-1:0] br_cnt, mp_cnt;

  // Retirement statistics. Both counters saturate at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (!stallM) begin
      if (branchM && (br_cnt != '1)) br_cnt <= br_cnt + CNT_W'(1);
      if (mispredM && (mp_cnt != '1)) mp_cnt <= mp_cnt + CNT_W'(1);
    end
  end

  assign br_countM = br_cnt;
  assign mp_countM = mp_cnt;
`else
  assign br_countM = '0;
  assign mp_countM = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (PC_W=32, CNT_W=4).
module tb_branch_resolve;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             branchD, pred_takeD, stallE, flushE, stallM, flushM, actual_takeE;
  logic [PC_W-1:0]  pcD, targetD;
  logic             mispredictE, flush_frontE, branchM, actual_takeM, mispredM;
  logic [PC_W-1:0]  redirect_pcE, pcM;
  logic [CNT_W-1:0] br_countM, mp_countM;

  int checks = 0;
  int failures = 0;

  branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .branchD(branchD), .pred_takeD(pred_takeD),
    .pcD(pcD), .targetD(targetD), .stallE(stallE), .flushE(flushE),
    .stallM(stallM), .flushM(flushM), .actual_takeE(actual_takeE),
    .mispredictE(mispredictE), .redirect_pcE(redirect_pcE),
    .flush_frontE(flush_frontE), .branchM(branchM), .actual_takeM(actual_takeM),
    .pcM(pcM), .mispredM(mispredM), .br_countM(br_countM), .mp_countM(mp_countM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; inputs change and outputs settle here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_d(input logic br, input logic pt, input logic [PC_W-1:0] pc,
                       input logic [PC_W-1:0] tg);
    branchD = br; pred_takeD = pt; pcD = pc; targetD = tg;
  endtask

  // one branch through D, E, M with no stalls; it is retired when the task returns
  task automatic run_branch(input logic [PC_W-1:0] pc, input logic pt, input logic act);
    put_d(1'b1, pt, pc, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = act;
    cyc();
    actual_takeE = 1'b0;
    cyc();
  endtask

  initial begin
    resetn = 1'b0;
    put_d(1'b0, 1'b0, '0, '0);
    stallE = 0; flushE = 0; stallM = 0; flushM = 0; actual_takeE = 0;
    #3;
    chk("rst_mispredictE", mispredictE, 0);
    chk("rst_redirect", redirect_pcE, 0);
    chk("rst_branchM", branchM, 0);
    chk("rst_pcM", pcM, 0);
    #4 resetn = 1'b1;
    cyc();

    // correct prediction
    put_d(1'b1, 1'b1, 32'h100, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b1;
    #2;
    chk("ok_mispredictE", mispredictE, 0);
    chk("ok_flush", flush_frontE, 0);
    chk("ok_redirect", redirect_pcE, 0);
    cyc();
    actual_takeE = 1'b0;
    #2;
    chk("ok_branchM", branchM, 1);
    chk("ok_actual_takeM", actual_takeM, 1);
    chk("ok_pcM", pcM, 32'h100);
    chk("ok_mispredM", mispredM, 0);
    cyc();
    chk("ok_branchM_pulse", branchM, 0);

    // predicted taken, actually not taken
    put_d(1'b1, 1'b1, 32'h100, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b0;
    #2;
    chk("nt_mispredictE", mispredictE, 1);
    chk("nt_redirect", redirect_pcE, 32'h108);
    chk("nt_flush", flush_frontE, 1);
    cyc();
    chk("nt_mispredM", mispredM, 1);
    chk("nt_actual_takeM", actual_takeM, 0);
    chk("nt_flush_gone", flush_frontE, 0);
    cyc();

    // predicted not-taken, actually taken, held in E by three stall cycles
    put_d(1'b1, 1'b0, 32'h100, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b1;
    stallE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stallE = 1'b0;
      #2;
      chk($sformatf("st_mispredictE%0d", i), mispredictE, 1);
      chk($sformatf("st_redirect%0d", i), redirect_pcE, 32'h200);
      chk($sformatf("st_flush%0d", i), flush_frontE, (i == 0) ? 1 : 0);
      chk($sformatf("st_branchM%0d", i), branchM, 0);
      cyc();
    end
    actual_takeE = 1'b0;
    chk("st_branchM", branchM, 1);
    chk("st_mispredM", mispredM, 1);
    chk("st_actual_takeM", actual_takeM, 1);
    chk("st_e_empty", mispredictE, 0);
    cyc();
    chk("st_branchM_once", branchM, 0);

    // flushE squashes a branch entering E
    put_d(1'b1, 1'b1, 32'h100, 32'h200);
    flushE = 1'b1;
    cyc();
    flushE = 1'b0;
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b0;
    #2;
    chk("fl_mispredictE", mispredictE, 0);
    cyc();
    chk("fl_branchM", branchM, 0);

    // fallthrough address wraps around
    put_d(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b0;
    #2;
    chk("wr_mispredictE", mispredictE, 1);
    chk("wr_redirect", redirect_pcE, 32'h4);
    cyc();
    chk("wr_pcM", pcM, 32'hFFFF_FFFC);
    cyc();

    // flushM drops a branch on its way into M
    put_d(1'b1, 1'b0, 32'h300, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    flushM = 1'b1;
    cyc();
    flushM = 1'b0;
    chk("fm_branchM", branchM, 0);

    // stallM holds the M branch
    put_d(1'b1, 1'b1, 32'h400, 32'h200);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b1;
    cyc();
    actual_takeE = 1'b0;
    stallM = 1'b1;
    chk("sm_pcM", pcM, 32'h400);
    cyc();
    stallM = 1'b0;
    chk("sm_hold_branchM", branchM, 1);
    chk("sm_hold_pcM", pcM, 32'h400);
    cyc();
    chk("sm_branchM_gone", branchM, 0);

    // Retired so far: 5 branches and 3 mispredicts. Two more mispredicts follow.
    run_branch(32'h500, 1'b1, 1'b0);
    run_branch(32'h504, 1'b0, 1'b1);
    cyc();
`ifdef BRANCH_STAT_EN
    chk("cnt_br7", br_countM, 7);
    chk("cnt_mp5", mp_countM, 5);
`else
    chk("cnt_br_tied", br_countM, 0);
    chk("cnt_mp_tied", mp_countM, 0);
`endif
    for (int i = 0; i < 18; i++) run_branch(32'h600 + PC_W'(i * 4), 1'b1, 1'b1);
    cyc();
`ifdef BRANCH_STAT_EN
    chk("cnt_br_sat", br_countM, 4'hF);
    chk("cnt_mp_keep", mp_countM, 5);
`else
    chk("cnt_br_tied2", br_countM, 0);
    chk("cnt_mp_tied2", mp_countM, 0);
`endif

    // asynchronous reset while a mispredicted branch is stalled in E
    put_d(1'b1, 1'b0, 32'h700, 32'h800);
    cyc();
    put_d(1'b0, 1'b0, '0, '0);
    actual_takeE = 1'b1;
    stallE = 1'b1;
    #2;
    chk("ar_pre_mispredictE", mispredictE, 1);
    resetn = 1'b0;
    #1;
    chk("ar_mispredictE", mispredictE, 0);
    chk("ar_redirect", redirect_pcE, 0);
    chk("ar_flush", flush_frontE, 0);
    chk("ar_branchM", branchM, 0);
    chk("ar_br_count", br_countM, 0);
    chk("ar_mp_count", mp_countM, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
